// File: rtl/count_nox_param.sv
// count_nox_param
// ---------------
// Scans a window of a synchronous ROM and counts the words that satisfy a
// selectable unsigned comparison against a latched search operand.
//
// Handshake: the block starts when go is seen high in IDLE. The result is
// presented as a level: done stays high, with freq stable, until go is seen
// low. There is no back-pressure. The memory is addressed directly, and
// mem_data must be valid one cycle after mem_addr/mem_rd.
//
// Optional feature macro: COUNT_FIRST_IDX_EN adds first_idx/found outputs.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   go                start request (sampled in IDLE)
//   x, x_hi, mode     search operand, RANGE high bound, compare select
//                     (00 EQ, 01 LT, 10 GT, 11 RANGE x<=d<=x_hi)
//   base, len         scan window start address and word count (0..2^ADDR_W)
//   mem_addr, mem_rd  memory address and read enable
//   mem_data          memory read data (one-cycle latency)
//   freq              match count, saturating at all-ones
//   done              result valid (level)
//   busy              high in SCAN and DRAIN
//   first_idx, found  (COUNT_FIRST_IDX_EN) address of first match, any-match flag
//   dbg_state         current FSM state (IDLE=0, SCAN=1, DRAIN=2, DONE=3)
module count_nox_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] x_hi,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [CNT_W-1:0]  freq,
    output logic              done,
    output logic              busy,
`ifdef COUNT_FIRST_IDX_EN
    output logic [ADDR_W-1:0] first_idx,
    output logic              found,
`endif
    output logic [1:0]        dbg_state
);

    // The scan index must reach 2^ADDR_W, so it is one bit wider than an address.
    localparam int SCAN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   x_q, x_hi_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [SCAN_W-1:0]   len_q;
    logic [SCAN_W-1:0]   idx_q;
    logic                cmp_vld_q;
    logic [CNT_W-1:0]    freq_q;
    logic                done_q;
    logic                start;
    logic                scan_last;
    logic                hit;

`ifdef COUNT_FIRST_IDX_EN
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic [ADDR_W-1:0]   first_idx_q;
    logic                found_q;
`endif

    assign start     = (state_q == S_IDLE) && go;
    assign scan_last = (idx_q + SCAN_W'(1)) == len_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = (len == '0) ? S_DONE : S_SCAN;
            S_SCAN:  if (scan_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (!go) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; the address is zero outside SCAN so reset leaves it at 0.
    always_comb begin
        mem_rd    = (state_q == S_SCAN);
        mem_addr  = '0;
        if (state_q == S_SCAN) begin
            mem_addr = base_q + idx_q[ADDR_W-1:0];
        end
        busy      = (state_q == S_SCAN) || (state_q == S_DRAIN);
        dbg_state = state_q;
    end

    // Comparison on the data returned for the previously issued address.
    always_comb begin
        hit = 1'b0;
        case (mode_q)
            2'b00: hit = (mem_data == x_q);
            2'b01: hit = (mem_data <  x_q);
            2'b10: hit = (mem_data >  x_q);
            2'b11: hit = (mem_data >= x_q) && (mem_data <= x_hi_q);
            default: hit = 1'b0;
        endcase
    end

    // Datapath: operand latch, scan index, match counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            x_hi_q    <= '0;
            mode_q    <= '0;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            cmp_vld_q <= 1'b0;
            freq_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            // Data for an address issued in SCAN is compared one cycle later.
            cmp_vld_q <= (state_q == S_SCAN);
            // done trails the DONE state by one edge, so it rises after the
            // final count has been held for a full cycle.
            done_q    <= (state_q == S_DONE);
            if (start) begin
                x_q    <= x;
                x_hi_q <= x_hi;
                mode_q <= mode;
                base_q <= base;
                len_q  <= SCAN_W'(len);
                idx_q  <= '0;
                freq_q <= '0;
            end else begin
                if (state_q == S_SCAN) begin
                    idx_q <= idx_q + SCAN_W'(1);
                end
                // Saturate rather than wrap when CNT_W is narrowed.
                if (cmp_vld_q && hit && (freq_q != '1)) begin
                    freq_q <= freq_q + CNT_W'(1);
                end
            end
        end
    end

    assign freq = freq_q;
    assign done = done_q;

`ifdef COUNT_FIRST_IDX_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_addr_q  <= '0;
            first_idx_q <= '0;
            found_q     <= 1'b0;
        end else begin
            // Pair each returned word with the address that fetched it.
            cmp_addr_q <= mem_addr;
            if (start) begin
                first_idx_q <= '0;
                found_q     <= 1'b0;
            end else if (cmp_vld_q && hit && !found_q) begin
                first_idx_q <= cmp_addr_q;
                found_q     <= 1'b1;
            end
        end
    end

    assign first_idx = first_idx_q;
    assign found     = found_q;
`endif

endmodule

// File: tb/tb_count_nox_param.sv
// Bench for count_nox_param: ROM model, reference model, scoreboard.
module tb_count_nox_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 9;

    logic              clk;
    logic              reset;
    logic              go;
    logic [DATA_W-1:0] x, x_hi;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  len;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [CNT_W-1:0]  freq;
    logic              done;
    logic              busy;
    logic [1:0]        dbg_state;
`ifdef COUNT_FIRST_IDX_EN
    logic [ADDR_W-1:0] first_idx;
    logic              found;
`endif

    count_nox_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .x         (x),
        .x_hi      (x_hi),
        .mode      (mode),
        .base      (base),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .freq      (freq),
        .done      (done),
        .busy      (busy),
`ifdef COUNT_FIRST_IDX_EN
        .first_idx (first_idx),
        .found     (found),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- synchronous ROM model ----------------
    logic [DATA_W-1:0] rom [256];
    always_ff @(posedge clk) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [CNT_W-1:0]  exp_q[$];
`ifdef COUNT_FIRST_IDX_EN
    logic [ADDR_W:0]   exp_fi_q[$];   // {found, first_idx}
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the window with plain modular arithmetic.
    function automatic logic [CNT_W-1:0] ref_count(input int m, input int xx, input int xh,
                                                   input int b, input int n,
                                                   output bit f, output int fi);
        int cnt;
        cnt = 0;
        f   = 0;
        fi  = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            int d;
            bit hit;
            a = (b + i) % 256;
            d = int'(rom[a]);
            case (m)
                0: hit = (d == xx);
                1: hit = (d < xx);
                2: hit = (d > xx);
                default: hit = (d >= xx) && (d <= xh);
            endcase
            if (hit) begin
                cnt++;
                if (!f) begin
                    f  = 1;
                    fi = a;
                end
            end
        end
        if (cnt > (1 << CNT_W) - 1) cnt = (1 << CNT_W) - 1;
        return CNT_W'(cnt);
    endfunction

    // Monitor: every rising edge of done pops one expected result.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                check("freq", 32'(freq), 32'(exp_q.pop_front()));
`ifdef COUNT_FIRST_IDX_EN
                begin
                    logic [ADDR_W:0] e;
                    e = exp_fi_q.pop_front();
                    check("found", 32'(found), 32'(e[ADDR_W]));
                    if (e[ADDR_W]) check("first_idx", 32'(first_idx), 32'(e[ADDR_W-1:0]));
                end
`endif
            end
        end
        done_prev = done;
    end

    // ---------------- driver ----------------
    task automatic scramble();
        x    = DATA_W'($urandom);
        x_hi = DATA_W'($urandom);
        mode = 2'($urandom);
        base = ADDR_W'($urandom);
        len  = CNT_W'($urandom_range(0, 256));
    endtask

    task automatic run(input int m, input int xx, input int xh, input int b, input int n,
                       input bit hold);
        bit f;
        int fi;
        int lat;
        int rd_cnt;
        exp_q.push_back(ref_count(m, xx, xh, b, n, f, fi));
`ifdef COUNT_FIRST_IDX_EN
        exp_fi_q.push_back({f, ADDR_W'(fi)});
`endif
        @(negedge clk);
        mode = 2'(m);
        x    = DATA_W'(xx);
        x_hi = DATA_W'(xh);
        base = ADDR_W'(b);
        len  = CNT_W'(n);
        go   = 1'b1;
        @(posedge clk);               // edge T: go sampled
        #1;
        go = hold;
        rd_cnt = mem_rd ? 1 : 0;
        scramble();
        lat = 0;
        while (!done && lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
            if (mem_rd) rd_cnt++;
            scramble();
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        end
        check("done_latency", 32'(lat), 32'((n == 0) ? 1 : n + 2));
        check("rd_cycles", 32'(rd_cnt), 32'(n));
        check("busy_at_done", 32'(busy), 32'(0));
        if (hold) begin
            repeat (6) @(posedge clk);
            #1;
            check("hold_done", 32'(done), 32'(1));
            check("hold_no_restart", 32'(busy | mem_rd), 32'(0));
            go = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("done_fall", 32'(done), 32'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        go    = 1'b0;
        x = '0; x_hi = '0; mode = '0; base = '0; len = '0;
        for (int i = 0; i < 256; i++) rom[i] = DATA_W'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_freq", 32'(freq), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_mem_rd", 32'(mem_rd), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        reset = 1'b0;

        // Directed: identity ROM
        run(0, 0,  0,  0,   256, 0);     // EQ  -> 1
        run(1, 16, 0,  0,   256, 0);     // LT  -> 16
        run(2, 200, 0, 0,   256, 0);     // GT  -> 55, first 201
        run(3, 10, 19, 250, 20,  0);     // RANGE with wrap -> 4
        run(3, 19, 10, 250, 20,  0);     // empty range -> 0
        run(int'($urandom_range(0, 3)), 7, 9, 3, 0, 0);   // len 0

        // Reset in the middle of a scan
        @(negedge clk);
        mode = 2'b01; x = 8'd200; base = '0; len = CNT_W'(256); go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_freq", 32'(freq), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_mem_rd", 32'(mem_rd), 32'(0));
        check("midrst_mem_addr", 32'(mem_addr), 32'(0));
        check("midrst_state", 32'(dbg_state), 32'(0));
        reset = 1'b0;
        run(0, 5, 0, 0, 256, 0);         // EQ x=5 -> 1

        // go held through DONE, then a fresh scan
        run(0, 7, 0, 0, 30, 1);
        run(1, 3, 0, 0, 10, 0);

        // Randomized runs over random ROM contents
        for (int i = 0; i < 256; i++) rom[i] = DATA_W'($urandom_range(0, 63));
        for (int r = 0; r < 25; r++) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 63)), int'($urandom_range(0, 255)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 256)),
                bit'($urandom_range(0, 1)));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1000000");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
